// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
//   mode_e      : arbitration mode encoding (00 select, 01 priority, 1x round-robin)
//   min_swidth  : smallest channel-index width able to address num_ch channels
package mux_pkg;

  typedef enum logic [1:0] {
    MODE_SEL    = 2'b00,
    MODE_PRIO   = 2'b01,
    MODE_RR     = 2'b10,
    MODE_RR_ALT = 2'b11
  } mode_e;

  function automatic int unsigned min_swidth(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational channel arbiter.
//   req       : per-channel request (in_valid)
//   ptr       : round-robin start channel
//   mode      : mode_e encoding
//   sel       : channel index used in select mode
//   grant     : one-hot grant (zero when nothing granted)
//   grant_idx : index of the granted channel (0 when nothing granted)
//   any_grant : a channel is granted
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned num_ch = 16,
  parameter int unsigned swidth = 4
) (
  input  logic [num_ch-1:0] req,
  input  logic [swidth-1:0] ptr,
  input  logic [1:0]        mode,
  input  logic [swidth-1:0] sel,
  output logic [num_ch-1:0] grant,
  output logic [swidth-1:0] grant_idx,
  output logic              any_grant
);

  logic [2*num_ch-1:0] req_dbl;
  logic [num_ch-1:0]   req_rot;

  // Rotating a doubled copy right by ptr puts channel ptr at bit 0, so the
  // round-robin search becomes a lowest-set-bit search on req_rot.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[num_ch-1:0];

  function automatic logic [swidth-1:0] wrap_idx(input int unsigned base,
                                                 input int unsigned off);
    int unsigned s;
    s = base + off;
    if (s >= num_ch) s = s - num_ch;
    return swidth'(s);
  endfunction

  always_comb begin
    grant_idx = '0;
    any_grant = 1'b0;
    case (mode_e'(mode))
      MODE_SEL: begin
        // Only indices below num_ch are compared, so an out-of-range sel never grants.
        for (int unsigned k = 0; k < num_ch; k++) begin
          if (sel == swidth'(k) && req[k]) begin
            grant_idx = swidth'(k);
            any_grant = 1'b1;
          end
        end
      end
      MODE_PRIO: begin
        // Descending scan: the last hit, i.e. the lowest index, wins.
        for (int unsigned k = num_ch; k > 0; k--) begin
          if (req[k-1]) begin
            grant_idx = swidth'(k - 1);
            any_grant = 1'b1;
          end
        end
      end
      default: begin
        for (int unsigned k = num_ch; k > 0; k--) begin
          if (req_rot[k-1]) begin
            grant_idx = wrap_idx(32'(ptr), k - 1);
            any_grant = 1'b1;
          end
        end
      end
    endcase
  end

  assign grant = any_grant ? (num_ch'(1) << grant_idx) : '0;

endmodule

// File: rtl/mux_rr_stream.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_data             : flattened channel data, channel k at [k*width +: width]
//   in_valid / in_ready : per-channel handshake (at most one ready high)
//   mode, sel           : arbitration mode and direct-select channel
//   out_data / out_ch   : held beat and the channel that supplied it
//   out_valid/out_ready : output handshake
module mux_rr_stream
  import mux_pkg::*;
#(
  parameter int unsigned width  = 4,
  parameter int unsigned num_ch = 16,
  parameter int unsigned swidth = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [num_ch*width-1:0] in_data,
  input  logic [num_ch-1:0]       in_valid,
  output logic [num_ch-1:0]       in_ready,
  input  logic [1:0]              mode,
  input  logic [swidth-1:0]       sel,
  output logic [width-1:0]        out_data,
  output logic [swidth-1:0]       out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  if (swidth < min_swidth(num_ch)) begin : g_bad_swidth
    $error("swidth too small for num_ch");
  end

  logic [width-1:0]  out_data_q, out_data_d;
  logic [swidth-1:0] out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;
  logic [swidth-1:0] rr_ptr_q, rr_ptr_d;

  logic [num_ch-1:0] grant;
  logic [swidth-1:0] grant_idx;
  logic              any_grant;
  logic              load_en;
  logic              xfer;
  logic [width-1:0]  grant_data;

  rr_arbiter #(
    .num_ch (num_ch),
    .swidth (swidth)
  ) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .mode      (mode),
    .sel       (sel),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign load_en  = !out_valid_q || out_ready;
  assign xfer     = any_grant && load_en;
  assign in_ready = (rst_n && load_en) ? grant : '0;

  always_comb begin
    grant_data = '0;
    for (int unsigned k = 0; k < num_ch; k++) begin
      if (grant[k]) grant_data = grant_data | in_data[k*width +: width];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_ch_d    = grant_idx;
      rr_ptr_d    = (grant_idx == swidth'(num_ch - 1)) ? '0 : grant_idx + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_stream.sv
module tb_mux_rr_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_data;
  logic [15:0] in_valid;
  logic [15:0] rdy16;
  logic [11:0] rdy12;
  logic [1:0]  mode;
  logic [3:0]  sel;
  logic        out_ready;
  logic [3:0]  od16, od12, oc16, oc12;
  logic        ov16, ov12;

  always #5 clk = ~clk;

  mux_rr_stream #(.width(4), .num_ch(16), .swidth(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy16), .mode(mode), .sel(sel), .out_data(od16),
    .out_ch(oc16), .out_valid(ov16), .out_ready(out_ready)
  );

  mux_rr_stream #(.width(4), .num_ch(12), .swidth(4)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[47:0]), .in_valid(in_valid[11:0]),
    .in_ready(rdy12), .mode(mode), .sel(sel), .out_data(od12),
    .out_ch(oc12), .out_valid(ov12), .out_ready(out_ready)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: index 0 models the 16-channel instance, index 1 the 12-channel one.
  int         nch[2] = '{16, 12};
  bit         m_v[2];
  logic [3:0] m_d[2];
  int         m_ch[2];
  int         m_ptr[2];

  function automatic int pick(input int n, input int ptr);
    if (mode == 2'b00) begin
      if (int'(sel) < n && in_valid[sel]) return int'(sel);
      return -1;
    end
    if (mode == 2'b01) begin
      for (int i = 0; i < n; i++) if (in_valid[i]) return i;
      return -1;
    end
    for (int o = 0; o < n; o++) begin
      int c;
      c = (ptr + o) % n;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [15:0] exp_ready(input int i);
    int g;
    if (!rst_n) return 16'h0;
    if (m_v[i] && !out_ready) return 16'h0;
    g = pick(nch[i], m_ptr[i]);
    if (g < 0) return 16'h0;
    return 16'(1) << g;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int g;
      g = pick(nch[i], m_ptr[i]);
      if (!rst_n) begin
        m_v[i] = 0; m_d[i] = 4'h0; m_ch[i] = 0; m_ptr[i] = 0;
      end else if ((!m_v[i] || out_ready) && g >= 0) begin
        m_v[i]   = 1;
        m_d[i]   = in_data[g*4 +: 4];
        m_ch[i]  = g;
        m_ptr[i] = (g + 1) % nch[i];
      end else if (out_ready) begin
        m_v[i] = 0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_eq("in_ready16", 32'(rdy16), 32'(exp_ready(0)));
    check_eq("in_ready12", 32'(rdy12), 32'(exp_ready(1)));
    @(posedge clk);
    model_edge();
    #1;
    check_eq("out_valid16", 32'(ov16), 32'(m_v[0]));
    check_eq("out_data16",  32'(od16), 32'(m_d[0]));
    check_eq("out_ch16",    32'(oc16), 32'(m_ch[0]));
    check_eq("out_valid12", 32'(ov12), 32'(m_v[1]));
    check_eq("out_data12",  32'(od12), 32'(m_d[1]));
    check_eq("out_ch12",    32'(oc12), 32'(m_ch[1]));
  endtask

  logic [3:0] held;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 0; m_d[i] = 4'h0; m_ch[i] = 0; m_ptr[i] = 0;
    end
    rst_n = 1'b0; mode = 2'b00; sel = 4'd0; in_valid = 16'h0;
    in_data = 64'h0; out_ready = 1'b0;
    #1;
    cycle();
    cycle();
    check_eq("reset_valid", 32'(ov16), 32'h0);
    check_eq("reset_ch",    32'(oc16), 32'h0);

    // Direct select of channel 3
    rst_n = 1'b1; mode = 2'b00; sel = 4'd3; in_valid = 16'h0008;
    in_data = {$urandom, $urandom}; in_data[15:12] = 4'hD; out_ready = 1'b1;
    cycle();
    check_eq("s1_data",  32'(od16), 32'hD);
    check_eq("s1_ch",    32'(oc16), 32'd3);
    check_eq("s1_valid", 32'(ov16), 32'd1);

    // Direct select of channel 5 with backpressure
    sel = 4'd5; in_valid = 16'hFFFF; in_data = {$urandom, $urandom};
    cycle();
    held = od16;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = {$urandom, $urandom};
      cycle();
      check_eq("s2_hold_data",  32'(od16), 32'(held));
      check_eq("s2_hold_ready", 32'(rdy16), 32'h0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = {$urandom, $urandom};
      cycle();
      check_eq("s2_b2b_ch",    32'(oc16), 32'd5);
      check_eq("s2_b2b_valid", 32'(ov16), 32'd1);
    end

    // Fixed priority
    mode = 2'b01; in_valid = 16'hA004;
    for (int i = 0; i < 3; i++) begin
      in_data = {$urandom, $urandom};
      cycle();
      check_eq("s3_prio_ch2", 32'(oc16), 32'd2);
    end
    in_valid = 16'hA000;
    for (int i = 0; i < 2; i++) begin
      in_data = {$urandom, $urandom};
      cycle();
      check_eq("s3_prio_ch13", 32'(oc16), 32'd13);
    end

    // Reset while a beat is held
    mode = 2'b10; in_valid = 16'hFFFF;
    cycle();
    out_ready = 1'b0;
    cycle();
    rst_n = 1'b0;
    cycle();
    check_eq("s4_rst_valid", 32'(ov16), 32'h0);
    check_eq("s4_rst_ch",    32'(oc16), 32'h0);

    // Round-robin sweep with wrap
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = {$urandom, $urandom};
      cycle();
      check_eq("s4_rr_ch",    32'(oc16), 32'(i % 16));
      check_eq("s4_rr_valid", 32'(ov16), 32'd1);
    end

    // Wrap between channels 15 and 0
    in_valid = 16'h4000;
    cycle();
    in_valid = 16'h8001;
    for (int i = 0; i < 3; i++) begin
      in_data = {$urandom, $urandom};
      cycle();
      check_eq("s5_wrap_ch", 32'(oc16), (i == 1) ? 32'd0 : 32'd15);
    end

    // Select beyond num_ch on the 12-channel instance
    mode = 2'b00; sel = 4'd15; in_valid = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      in_data = {$urandom, $urandom};
      cycle();
      check_eq("s6_sel_oob_valid", 32'(ov12), 32'h0);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      mode      = 2'($urandom);
      sel       = 4'($urandom);
      in_valid  = 16'($urandom);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
